// File: rtl/reg_scoreboard_interlock.sv
// reg_scoreboard_interlock
// Producer-side tracker for in-flight register writes in the 5-stage RV64 pipeline.
// Each architectural register carries a pending bit, a load flag and a stage age
// (0 = EX, 1 = MEM, 2 = WB). The ID-stage source lookup is combinational from this
// registered state: it raises a load-use stall and picks the forwarding source.
//
// Optional feature macro: SCOREBOARD_STATS_EN
//   When defined, adds free-running 32-bit stall_cycles and flush_count outputs.
//   When undefined, neither port nor counter exists.
//
// Reset is synchronous and active low. While rst_n is low the lookup outputs are
// forced to zero, so no stall is ever held across a reset.

module reg_scoreboard_interlock #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int RETIRE_AGE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic                issue_we,
  input  logic                issue_is_load,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic                rs1_used,
  input  logic                rs2_used,
  input  logic                flush,
  output logic                stall,
  output logic                issue_fire,
  output logic [1:0]          fwd_rs1_sel,
  output logic [1:0]          fwd_rs2_sel,
  output logic [NUM_REGS-1:0] busy_vec
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count
`endif
);

  localparam logic [1:0] RETIRE_AGE_C = 2'(RETIRE_AGE);

  // Registered scoreboard state, one slot per architectural register.
  logic [NUM_REGS-1:0]      pending_r;
  logic [NUM_REGS-1:0]      is_load_r;
  logic [NUM_REGS-1:0][1:0] age_r;

  // Lookup results: bit 2 = stall request, bits 1:0 = forward select.
  logic [2:0] rs1_res_s;
  logic [2:0] rs2_res_s;
  logic       stall_s;
  logic       issue_fire_s;
  logic       alloc_s;

  // Resolves one source operand against its scoreboard slot.
  // A load still in EX cannot forward yet, so it stalls and reads the regfile path.
  function automatic logic [2:0] lookup_f(
    input logic       used,
    input logic       nonzero,
    input logic       pend,
    input logic       ld,
    input logic [1:0] age
  );
    logic [2:0] res;
    res = 3'b000;
    if (used && nonzero && pend) begin
      case (age)
        2'd0: begin
          if (ld) begin
            res = 3'b100;
          end else begin
            res = 3'b001;
          end
        end
        2'd1:    res = 3'b010;
        2'd2:    res = 3'b011;
        default: res = 3'b000;
      endcase
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  // Source lookup against registered state; the issuing instruction's own entry is not yet visible.
  always_comb begin
    rs1_res_s = lookup_f(rs1_used, rs1 != {ADDR_W{1'b0}}, pending_r[rs1],
                         is_load_r[rs1], age_r[rs1]);
    rs2_res_s = lookup_f(rs2_used, rs2 != {ADDR_W{1'b0}}, pending_r[rs2],
                         is_load_r[rs2], age_r[rs2]);
  end

  // Interlock and issue qualification; everything is held at zero while in reset.
  always_comb begin
    stall_s      = 1'b0;
    issue_fire_s = 1'b0;
    alloc_s      = 1'b0;
    if (rst_n) begin
      stall_s      = rs1_res_s[2] | rs2_res_s[2];
      issue_fire_s = issue_valid & ~stall_s & ~flush;
      alloc_s      = issue_fire_s & issue_we & (issue_rd != {ADDR_W{1'b0}});
    end else begin
      stall_s      = 1'b0;
      issue_fire_s = 1'b0;
      alloc_s      = 1'b0;
    end
  end

  assign stall       = stall_s;
  assign issue_fire  = issue_fire_s;
  assign fwd_rs1_sel = rst_n ? rs1_res_s[1:0] : 2'b00;
  assign fwd_rs2_sel = rst_n ? rs2_res_s[1:0] : 2'b00;
  assign busy_vec    = pending_r;

  // Age every in-flight entry, retire WB entries, squash EX entries on flush, then allocate the new writer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r <= {NUM_REGS{1'b0}};
      is_load_r <= {NUM_REGS{1'b0}};
      age_r     <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (pending_r[i]) begin
          if (flush && (age_r[i] == 2'd0)) begin
            pending_r[i] <= 1'b0;
            is_load_r[i] <= 1'b0;
            age_r[i]     <= 2'd0;
          end else if (age_r[i] >= RETIRE_AGE_C) begin
            pending_r[i] <= 1'b0;
            is_load_r[i] <= 1'b0;
            age_r[i]     <= 2'd0;
          end else begin
            age_r[i]     <= age_r[i] + 2'd1;
          end
        end
      end
      // Youngest writer wins: this assignment overrides any older entry or same-cycle retire.
      if (alloc_s) begin
        pending_r[issue_rd] <= 1'b1;
        is_load_r[issue_rd] <= issue_is_load;
        age_r[issue_rd]     <= 2'd0;
      end
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] flush_count_r;

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_r <= 32'd0;
      flush_count_r  <= 32'd0;
    end else begin
      if (stall_s) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
      if (flush) begin
        flush_count_r <= flush_count_r + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign flush_count  = flush_count_r;
`endif

endmodule

// File: tb/tb_reg_scoreboard_interlock.sv
// Self-checking bench for reg_scoreboard_interlock.
// The reference model records, per register, the cycle in which its youngest writer
// issued; the stage age is derived arithmetically from the current cycle number.

module tb_reg_scoreboard_interlock;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_we;
  logic        issue_is_load;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_used;
  logic        rs2_used;
  logic        flush;
  logic        stall;
  logic        issue_fire;
  logic [1:0]  fwd_rs1_sel;
  logic [1:0]  fwd_rs2_sel;
  logic [31:0] busy_vec;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  reg_scoreboard_interlock dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_we      (issue_we),
    .issue_is_load (issue_is_load),
    .issue_rd      (issue_rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_used      (rs1_used),
    .rs2_used      (rs2_used),
    .flush         (flush),
    .stall         (stall),
    .issue_fire    (issue_fire),
    .fwd_rs1_sel   (fwd_rs1_sel),
    .fwd_rs2_sel   (fwd_rs2_sel),
    .busy_vec      (busy_vec)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model state
  int cyc;
  int iss_c  [32];
  bit iss_ld [32];
  int m_stall_cnt;
  int m_flush_cnt;
  bit first_cycle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int age_of(input int r);
    return cyc - iss_c[r] - 1;
  endfunction

  function automatic bit pend_of(input int r);
    int a;
    a = age_of(r);
    return (r != 0) && (a >= 0) && (a <= 2);
  endfunction

  task automatic m_look(input int src, input bit used, output bit st, output int sel);
    int a;
    st  = 1'b0;
    sel = 0;
    if (rst_n && used && src != 0 && pend_of(src)) begin
      a = age_of(src);
      if (a == 0) begin
        if (iss_ld[src]) st = 1'b1;
        else sel = 1;
      end else begin
        sel = a + 1;
      end
    end
  endtask

  bit e_stall;
  bit e_fire;
  int e_sel1;
  int e_sel2;

  task automatic m_eval();
    bit s1;
    bit s2;
    m_look(int'(rs1), rs1_used, s1, e_sel1);
    m_look(int'(rs2), rs2_used, s2, e_sel2);
    e_stall = s1 | s2;
    e_fire  = rst_n & issue_valid & ~e_stall & ~flush;
  endtask

  task automatic cmp_model();
    logic [31:0] eb;
    m_eval();
    chk("stall", 32'(stall), 32'(e_stall));
    chk("issue_fire", 32'(issue_fire), 32'(e_fire));
    chk("fwd_rs1_sel", 32'(fwd_rs1_sel), 32'(e_sel1));
    chk("fwd_rs2_sel", 32'(fwd_rs2_sel), 32'(e_sel2));
    if (!first_cycle) begin
      eb = 32'd0;
      for (int r = 0; r < 32; r++) eb[r] = pend_of(r);
      chk("busy_vec", busy_vec, eb);
`ifdef SCOREBOARD_STATS_EN
      chk("stall_cycles", stall_cycles, 32'(m_stall_cnt));
      chk("flush_count", flush_count, 32'(m_flush_cnt));
`endif
    end
  endtask

  task automatic drive(input bit rst, input bit v, input bit we, input bit ld, input int rd,
                       input int r1, input bit u1, input int r2, input bit u2, input bit fl);
    rst_n         = rst;
    issue_valid   = v;
    issue_we      = we;
    issue_is_load = ld;
    issue_rd      = 5'(rd);
    rs1           = 5'(r1);
    rs1_used      = u1;
    rs2           = 5'(r2);
    rs2_used      = u2;
    flush         = fl;
    #4;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Advance the model across the coming edge, then move the DUT across it.
  task automatic tick();
    m_eval();
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) iss_c[r] = -1000;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (e_stall) m_stall_cnt++;
      if (flush) begin
        m_flush_cnt++;
        for (int r = 0; r < 32; r++) if (pend_of(r) && age_of(r) == 0) iss_c[r] = -1000;
      end
      if (e_fire && issue_we && issue_rd != 5'd0) begin
        iss_c[issue_rd]  = cyc;
        iss_ld[issue_rd] = issue_is_load;
      end
    end
    cyc++;
    first_cycle = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++) begin
      idle();
      cmp_model();
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    first_cycle = 1'b1;
    for (int r = 0; r < 32; r++) begin
      iss_c[r]  = -1000;
      iss_ld[r] = 1'b0;
    end
    @(posedge clk);
    #1;

    // 1. Reset with random inputs
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom));
      cmp_model();
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_sel1", 32'(fwd_rs1_sel), 32'd0);
      tick();
    end
    idle();
    chk("rst_busy", busy_vec, 32'd0);
    cmp_model();
    tick();

    // 2. Load-use
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5, 0, 1'b0, 0, 1'b0, 1'b0);
    cmp_model();
    chk("lu_fire", 32'(issue_fire), 32'd1);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 6, 5, 1'b1, 0, 1'b0, 1'b0);
    cmp_model();
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_nofire", 32'(issue_fire), 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 6, 5, 1'b1, 0, 1'b0, 1'b0);
    cmp_model();
    chk("lu_stall_clr", 32'(stall), 32'd0);
    chk("lu_sel_mem", 32'(fwd_rs1_sel), 32'd2);
    tick();
`ifdef SCOREBOARD_STATS_EN
    idle();
    chk("stats_stall1", stall_cycles, 32'd1);
    tick();
`endif
    drain();

    // 3. ALU chain
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3, 0, 1'b0, 0, 1'b0, 1'b0);
    cmp_model();
    tick();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 10, 3, 1'b1, 3, 1'b1, 1'b0);
      cmp_model();
      chk("chain_sel1", 32'(fwd_rs1_sel), 32'(k));
      chk("chain_sel2", 32'(fwd_rs2_sel), 32'(k));
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 1'b1, 3, 1'b1, 1'b0);
    cmp_model();
    chk("chain_sel_done", 32'(fwd_rs1_sel), 32'd0);
    chk("chain_busy3", 32'(busy_vec[3]), 32'd0);
    tick();
    drain();

    // 4. WAW: younger load replaces older ALU entry
    drive(1'b1, 1'b1, 1'b1, 1'b0, 7, 0, 1'b0, 0, 1'b0, 1'b0);
    cmp_model();
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 7, 0, 1'b0, 0, 1'b0, 1'b0);
    cmp_model();
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 7, 1'b1, 1'b0);
    cmp_model();
    chk("waw_stall", 32'(stall), 32'd1);
    tick();
    drain();

    // 5. Flush squashes the EX-stage load
    drive(1'b1, 1'b1, 1'b1, 1'b1, 9, 0, 1'b0, 0, 1'b0, 1'b0);
    cmp_model();
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 9, 1'b1, 0, 1'b0, 1'b1);
    cmp_model();
    chk("flush_nofire", 32'(issue_fire), 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 9, 1'b1, 0, 1'b0, 1'b0);
    cmp_model();
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_sel", 32'(fwd_rs1_sel), 32'd0);
    chk("flush_busy9", 32'(busy_vec[9]), 32'd0);
    tick();
    drain();

    // 6. x0 never becomes pending
    drive(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    cmp_model();
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b1, 1'b0);
    cmp_model();
    chk("x0_busy", 32'(busy_vec[0]), 32'd0);
    chk("x0_sel", 32'(fwd_rs1_sel), 32'd0);
    chk("x0_stall", 32'(stall), 32'd0);
    tick();

    // Randomized traffic over a small register window to provoke hazards
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
            ($urandom_range(0, 7) == 0));
      cmp_model();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
